// File: rtl/t06_step_sequencer.sv
// t06_step_sequencer: game-step scheduler sequencing tick, move, collision check and apple respawn
module t06_step_sequencer #(
    parameter int             CW       = 24,
    parameter logic [CW-1:0]  TICK0    = 24'd8_000_000,
    parameter logic [CW-1:0]  TICK1    = 24'd6_000_000,
    parameter logic [CW-1:0]  TICK2    = 24'd4_000_000,
    parameter logic [CW-1:0]  TICK3    = 24'd2_000_000,
    parameter int             APPLE_TO = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       run,
    input  logic [1:0] game_speed,
    input  logic       move_done,
    input  logic       chk_valid,
    input  logic       good,
    input  logic       bad,
    input  logic       apple_ack,
    output logic       move_stb,
    output logic       chk_stb,
    output logic       grow,
    output logic       apple_req,
    output logic       game_over,
    output logic       busy,
    output logic       apple_err,
    output logic [7:0] step_count
);
    localparam int TW = $clog2(APPLE_TO + 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, WAIT_MOVE, WAIT_CHK, APPLE, HALT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] to_cnt;
    logic [CW-1:0] reload;
    logic          timeout;
    logic          finish;

    assign reload  = (game_speed == 2'd0 ? TICK0 :
                      game_speed == 2'd1 ? TICK1 :
                      game_speed == 2'd2 ? TICK2 : TICK3) - CW'(1);
    assign timeout = to_cnt == TW'(APPLE_TO - 1);
    // a step ends on a clean verdict or when the apple handshake resolves either way
    assign finish  = (state == WAIT_CHK && chk_valid && !bad && !good) ||
                     (state == APPLE && (apple_ack || timeout));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            cnt        <= '0;
            to_cnt     <= '0;
            move_stb   <= 1'b0;
            chk_stb    <= 1'b0;
            grow       <= 1'b0;
            apple_req  <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
            apple_err  <= 1'b0;
            step_count <= '0;
        end else if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            to_cnt     <= '0;
            move_stb   <= 1'b0;
            chk_stb    <= 1'b0;
            grow       <= 1'b0;
            apple_req  <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
            apple_err  <= 1'b0;
            step_count <= '0;
        end else begin
            move_stb <= 1'b0;
            chk_stb  <= 1'b0;
            grow     <= 1'b0;
            case (state)
                IDLE: if (run) begin
                    cnt   <= reload;
                    state <= WAIT_TICK;
                end
                WAIT_TICK: if (run) begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    else begin
                        move_stb <= 1'b1;
                        busy     <= 1'b1;
                        state    <= WAIT_MOVE;
                    end
                end
                WAIT_MOVE: if (move_done) begin
                    chk_stb <= 1'b1;
                    state   <= WAIT_CHK;
                end
                WAIT_CHK: if (chk_valid) begin
                    if (bad) begin
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                        state     <= HALT;
                    end else if (good) begin
                        grow      <= 1'b1;
                        apple_req <= 1'b1;
                        to_cnt    <= '0;
                        state     <= APPLE;
                    end
                end
                APPLE: begin
                    if (!apple_ack && timeout) apple_err <= 1'b1;
                    if (!apple_ack && !timeout) to_cnt <= to_cnt + TW'(1);
                end
                HALT: ;
                default: state <= IDLE;
            endcase
            if (finish) begin
                step_count <= step_count + 8'd1;
                cnt        <= reload;
                apple_req  <= 1'b0;
                busy       <= 1'b0;
                state      <= WAIT_TICK;
            end
        end
    end
endmodule

// File: tb/tb_t06_step_sequencer.sv
// tb_t06_step_sequencer: scoreboard bench with a responder, an event monitor and directed steps
module tb_t06_step_sequencer;
    logic       clk = 0, nrst = 0, clr = 0, run = 0;
    logic [1:0] game_speed = 2'd0;
    logic       move_done = 0, chk_valid = 0, good = 0, bad = 0, apple_ack = 0;
    logic       move_stb, chk_stb, grow, apple_req, game_over, busy, apple_err;
    logic [7:0] step_count;

    localparam int EV_MOVE = 0, EV_GROW = 1, EV_AFALL = 2, EV_OVER = 3;

    typedef struct {
        int   kind;
        int   gap;
        int   sc;
        logic err;
    } ev_t;

    ev_t  q[$];
    int   checks = 0, errors = 0;
    logic r_good = 0, r_bad = 0;
    int   r_ack = 0;
    logic md_pend = 0, rsp_prev_req = 0;
    int   ack_cnt = 0;
    int   cyc = 0, last = 0, kind;
    logic mon_prev_req = 0, mon_prev_over = 0;
    ev_t  e;
    string nm;
    int   n;

    t06_step_sequencer #(
        .TICK0(24'd4), .TICK1(24'd3), .TICK2(24'd2), .TICK3(24'd1), .APPLE_TO(8)
    ) dut (
        .clk(clk), .nrst(nrst), .clr(clr), .run(run), .game_speed(game_speed),
        .move_done(move_done), .chk_valid(chk_valid), .good(good), .bad(bad),
        .apple_ack(apple_ack), .move_stb(move_stb), .chk_stb(chk_stb), .grow(grow),
        .apple_req(apple_req), .game_over(game_over), .busy(busy),
        .apple_err(apple_err), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic expect_ev(int k, int gap, int sc, logic err);
        ev_t x;
        x.kind = k;
        x.gap  = gap;
        x.sc   = sc;
        x.err  = err;
        q.push_back(x);
    endtask

    task automatic chk_zero(string name);
        chk({name, "_flags"}, int'({move_stb, chk_stb, grow, apple_req, game_over, busy, apple_err}), 0);
        chk({name, "_step_count"}, int'(step_count), 0);
    endtask

    task automatic wait_move(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!move_stb && cnt < 200);
        if (!move_stb) chk("move_timeout", 0, 1);
    endtask

    // responder: move_done one cycle after move_stb, verdict alongside chk_stb, ack after r_ack cycles
    initial forever begin
        @(negedge clk);
        move_done = md_pend;
        md_pend   = move_stb;
        chk_valid = chk_stb;
        good      = chk_stb & r_good;
        bad       = chk_stb & r_bad;
        apple_ack = 1'b0;
        if (apple_req && !rsp_prev_req) ack_cnt = r_ack;
        rsp_prev_req = apple_req;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) apple_ack = 1'b1;
        end
    end

    // monitor: every output event is matched against the next scoreboard entry
    initial forever begin
        @(negedge clk);
        cyc++;
        kind = move_stb ? EV_MOVE : grow ? EV_GROW :
               (mon_prev_req && !apple_req) ? EV_AFALL :
               (game_over && !mon_prev_over) ? EV_OVER : -1;
        mon_prev_req  = apple_req;
        mon_prev_over = game_over;
        if (kind >= 0) begin
            if (q.size() == 0) chk("unexpected_event", kind, -1);
            else begin
                e  = q.pop_front();
                nm = e.kind == EV_MOVE ? "move" : e.kind == EV_GROW ? "grow" :
                     e.kind == EV_AFALL ? "apple_req_fall" : "game_over";
                chk({nm, "_kind"}, kind, e.kind);
                if (e.gap >= 0) chk({nm, "_gap"}, cyc - last, e.gap);
                chk({nm, "_step_count"}, int'(step_count), e.sc);
                chk({nm, "_apple_err"}, int'(apple_err), int'(e.err));
                chk({nm, "_busy"}, int'(busy), (e.kind == EV_MOVE || e.kind == EV_GROW) ? 1 : 0);
            end
            last = cyc;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        for (int i = 0; i < 4; i++) expect_ev(EV_MOVE, i == 0 ? -1 : 7, i, 1'b0);
        nrst = 1;
        run  = 1;
        for (int i = 0; i < 4; i++) wait_move(n);
        r_good = 1;
        r_ack  = 2;
        expect_ev(EV_GROW, 3, 3, 1'b0);
        expect_ev(EV_AFALL, 2, 4, 1'b0);
        expect_ev(EV_MOVE, 4, 4, 1'b0);
        wait_move(n);
        r_ack = 0;
        expect_ev(EV_GROW, 3, 4, 1'b0);
        expect_ev(EV_AFALL, 8, 5, 1'b1);
        expect_ev(EV_MOVE, 4, 5, 1'b1);
        wait_move(n);
        r_bad = 1;
        expect_ev(EV_OVER, 3, 5, 1'b1);
        repeat (55) @(negedge clk);
        chk("halt_game_over", int'(game_over), 1);
        chk("halt_apple_req", int'(apple_req), 0);
        chk("halt_step_count", int'(step_count), 5);
        clr = 1;
        @(negedge clk);
        chk_zero("clr");
        clr    = 0;
        run    = 0;
        r_good = 0;
        r_bad  = 0;
        repeat (3) @(negedge clk);
        chk_zero("idle");
        expect_ev(EV_MOVE, -1, 0, 1'b0);
        run = 1;
        repeat (2) @(negedge clk);
        run = 0;
        repeat (10) @(negedge clk);
        run = 1;
        wait_move(n);
        chk("resume_run_cycles", n, 3);
        repeat (2) @(negedge clk);
        run = 0;
        chk("wait_chk_busy", int'(busy), 1);
        repeat (4) @(negedge clk);
        chk("paused_step_count", int'(step_count), 1);
        chk("paused_busy", int'(busy), 0);
        expect_ev(EV_MOVE, -1, 1, 1'b0);
        for (int i = 2; i <= 257; i++) expect_ev(EV_MOVE, 4, i % 256, 1'b0);
        run = 1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) game_speed = 2'd3;
        end while (!move_stb && n < 50);
        chk("old_period", n, 4);
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        run = 0;
        chk("queue_drained", q.size(), 0);
        repeat (6) @(negedge clk);
        chk("wrap_step_count", int'(step_count), 2);
        #2 nrst = 0;
        #1 chk_zero("async_reset");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/t06_step_sequencer.md
# t06_step_sequencer

Central step scheduler for the snake game datapath, clocked by the main display clock. It owns the game-step cadence: it counts out one step period chosen by `game_speed`, strobes the body mover, then strobes the collision detector and waits for its verdict. On an apple hit it handshakes with the apple generator for a respawn; on a bad hit it halts the game. It replaces free-running step clocks with an explicit move → check → respawn sequence, so each step is atomic and ordered.

## Interface
Parameters:
- `CW`, 24: tick counter width.
- `TICK0`, 24'd8_000_000: step period in cycles for `game_speed` 2'b00 (slowest).
- `TICK1`, 24'd6_000_000: step period for 2'b01.
- `TICK2`, 24'd4_000_000: step period for 2'b10.
- `TICK3`, 24'd2_000_000: step period for 2'b11.
- `APPLE_TO`, 16: maximum cycles to wait for `apple_ack`.

Ports:
- `clk`  in  1  main clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous soft reset, from the reset button pulse.
- `run`  in  1  high while the game state is RUN.
- `game_speed`  in  2  selects the step period.
- `move_done`  in  1  one-cycle pulse: body shift complete.
- `chk_valid`  in  1  one-cycle pulse: collision verdict valid.
- `good`  in  1  apple hit, qualified by `chk_valid`.
- `bad`  in  1  wall or body hit, qualified by `chk_valid`.
- `apple_ack`  in  1  apple generator has placed a new apple.
- `move_stb`  out  1  one-cycle pulse: advance the snake.
- `chk_stb`  out  1  one-cycle pulse: run the collision check.
- `grow`  out  1  one-cycle pulse: lengthen the snake and increment the score.
- `apple_req`  out  1  level request for an apple respawn.
- `game_over`  out  1  level, high in HALT.
- `busy`  out  1  high while a step is in flight.
- `apple_err`  out  1  sticky flag: an apple handshake timed out.
- `step_count`  out  8  completed steps, wraps 255→0.

## Operation
- All outputs are registered. Reset (`nrst` low) or `clr` high puts the block in IDLE with every output 0, the tick counter at 0 and the timeout counter at 0. `clr` has priority over every transition.
- States: IDLE, WAIT_TICK, WAIT_MOVE, WAIT_CHK, APPLE, HALT.
- IDLE: when `run`=1, load the tick counter with TICKn−1, where n = `game_speed` sampled on this edge. Go to WAIT_TICK.
- WAIT_TICK:
  - `run`=0: the counter holds its value (pause). The state stays WAIT_TICK.
  - `run`=1 and counter≠0: decrement.
  - `run`=1 and counter=0: assert `move_stb` for one cycle and go to WAIT_MOVE.
- WAIT_MOVE: on `move_done`, assert `chk_stb` for one cycle and go to WAIT_CHK.
- WAIT_CHK, on `chk_valid`:
  - `bad`=1: go to HALT and set `game_over`=1. `bad` wins over a simultaneous `good`; there is no `grow` in that case.
  - else `good`=1: pulse `grow`, set `apple_req`=1, clear the timeout counter, go to APPLE.
  - else: finish the step.
- APPLE: `apple_req` stays high until `apple_ack` is sampled high, or until APPLE_TO cycles have elapsed without an ack. On timeout, set `apple_err`. Either way, drop `apple_req` and finish the step.
- Finish the step: increment `step_count`, reload the counter with TICKn−1 using the current `game_speed`, and go to WAIT_TICK.
- HALT: `game_over` stays held. Only `clr` or `nrst` exits HALT.
- A step in progress is atomic. Deasserting `run` in WAIT_MOVE, WAIT_CHK or APPLE does not abort the step; the pause takes effect in the next WAIT_TICK.
- A `game_speed` change takes effect only at the next reload.
- `busy` = 1 in WAIT_MOVE, WAIT_CHK and APPLE.
- Stray `move_done`, `chk_valid` or `apple_ack` pulses outside their wait state are ignored.

## Timing
- With `run` held high, `move_stb` rises on the P-th edge after the edge that entered WAIT_TICK, where P = TICKn.
- `move_done` may arrive at the earliest one cycle after `move_stb`. `chk_stb` follows `move_done` by 1 cycle.
- `grow` and `apple_req` rise 1 cycle after `chk_valid`. `apple_req` falls 1 cycle after `apple_ack` is sampled.
- Timeout: `apple_req` falls and `apple_err` rises on the same edge, APPLE_TO cycles after `apple_req` rose.
- `game_over` rises 1 cycle after a qualifying `bad`.
- Step period, with an immediate responder: P + 3 cycles without an apple, P + 4 with an immediate `apple_ack`.

## Test plan
Parameter overrides for the bench: TICK0=4, TICK1=3, TICK2=2, TICK3=1, APPLE_TO=8.
- Reset, then `run`=1, `game_speed`=0, responder returns `move_done` and `chk_valid` (good=bad=0) one cycle after each strobe → `move_stb` every 7 cycles; `step_count` reads 1, 2, 3; `grow`=0.
- `chk_valid` with `good`=1, `apple_ack` returned 2 cycles after `apple_req` → one `grow` pulse; `apple_req` high for 2 cycles; `step_count`+1; `apple_err`=0.
- `good`=1 and `apple_ack` never returned → `apple_req` high for 8 cycles, then 0; `apple_err`=1 and sticky; the next tick proceeds normally.
- `good`=1 and `bad`=1 in the same `chk_valid` → `game_over`=1, no `grow`, no `apple_req`, no further `move_stb` for 50 cycles; then a `clr` pulse → all outputs 0, state IDLE.
- `run`=0 for 10 cycles with the counter at 2, then `run`=1 → `move_stb` exactly 3 run-cycles later. Deassert `run` in WAIT_CHK → the step still completes and `step_count` increments.
- `game_speed` changed 0→3 mid-tick → the current period stays 4; the following period is 1. Drive 256 steps → `step_count` wraps to 0.
